// File: rtl/seg7_capture_decoder.sv
// Reads back a multiplexed 7-segment bus: filters unstable scans, captures each digit's value and
// counts illegal patterns. Define SEG_HEX_EN to also accept the hex glyphs A,b,C,d,E,F.
module seg7_capture_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic [6:0]                                        seg_i,
    input  logic [NUM_DIGITS-1:0]                             an_i,
    input  logic                                              clear_i,
    output logic [4*NUM_DIGITS-1:0]                           digits_o,
    output logic [NUM_DIGITS-1:0]                             digit_valid_o,
    output logic [NUM_DIGITS-1:0]                             digit_blank_o,
    output logic                                              update_o,
    output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] digit_idx_o,
    output logic                                              err_o,
    output logic [7:0]                                        err_count_o,
    output logic                                              all_captured_o
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_HOLD} state_t;

    // Returns {legal, blank, value}.
    function automatic logic [5:0] decode(input logic [6:0] s);
        logic [5:0] r;
        r = 6'b00_0000;
        case (s)
            7'b1111110: r = {2'b10, 4'h0};
            7'b0110000: r = {2'b10, 4'h1};
            7'b1101101: r = {2'b10, 4'h2};
            7'b1111001: r = {2'b10, 4'h3};
            7'b0110011: r = {2'b10, 4'h4};
            7'b1011011: r = {2'b10, 4'h5};
            7'b1011111: r = {2'b10, 4'h6};
            7'b1110000: r = {2'b10, 4'h7};
            7'b1111111: r = {2'b10, 4'h8};
            7'b1111011: r = {2'b10, 4'h9};
`ifdef SEG_HEX_EN
            7'b1110111: r = {2'b10, 4'hA};
            7'b0011111: r = {2'b10, 4'hB};
            7'b1001110: r = {2'b10, 4'hC};
            7'b0111101: r = {2'b10, 4'hD};
            7'b1001111: r = {2'b10, 4'hE};
            7'b1000111: r = {2'b10, 4'hF};
`else
`endif
            7'b0000000: r = {2'b01, 4'h0};
            default:    r = 6'b00_0000;
        endcase
        return r;
    endfunction

    logic [6:0]              seg_s_q, seg_p_q;
    logic [NUM_DIGITS-1:0]   an_s_q, an_p_q;
    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   valid_q, valid_d;
    logic [NUM_DIGITS-1:0]   blank_q, blank_d;
    logic [NUM_DIGITS-1:0]   capt_q, capt_d;
    logic                    update_q, update_d;
    logic                    err_q, err_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [7:0]              err_cnt_q, err_cnt_d;

    logic                    one_hot;
    logic                    changed;
    logic                    commit;
    logic [IDX_W-1:0]        an_idx;
    logic [5:0]              dec;

    assign one_hot = $onehot(an_s_q);
    assign changed = (seg_s_q != seg_p_q) || (an_s_q != an_p_q);
    assign dec     = decode(seg_s_q);

    always_comb begin
        an_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (an_s_q[i]) an_idx = IDX_W'(i);
        end
    end

    // Stability filter: count consecutive identical sample pairs while the anode is one-hot.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (one_hot) begin
                    state_d = S_SETTLE;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            S_SETTLE: begin
                if (!one_hot) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (changed) begin
                    cnt_d = CNT_W'(1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (changed) begin
                    state_d = one_hot ? S_SETTLE : S_IDLE;
                    cnt_d   = one_hot ? CNT_W'(1) : '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        if (state_d == S_SETTLE && cnt_d == CNT_W'(STABLE_CYCLES)) begin
            commit  = 1'b1;
            state_d = S_HOLD;
        end
        if (clear_i) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
    end

    always_comb begin
        digits_d  = digits_q;
        valid_d   = valid_q;
        blank_d   = blank_q;
        capt_d    = capt_q;
        idx_d     = idx_q;
        err_cnt_d = err_cnt_q;
        update_d  = 1'b0;
        err_d     = 1'b0;
        if (commit) begin
            update_d       = 1'b1;
            idx_d          = an_idx;
            capt_d[an_idx] = 1'b1;
            if (dec[5]) begin
                digits_d[an_idx*4 +: 4] = dec[3:0];
                valid_d[an_idx]         = 1'b1;
                blank_d[an_idx]         = 1'b0;
            end else if (dec[4]) begin
                digits_d[an_idx*4 +: 4] = 4'h0;
                valid_d[an_idx]         = 1'b0;
                blank_d[an_idx]         = 1'b1;
            end else begin
                // Illegal glyph: keep the last good nibble so a glitch does not erase it.
                valid_d[an_idx] = 1'b0;
                blank_d[an_idx] = 1'b0;
                err_d           = 1'b1;
                if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
            end
        end
        if (clear_i) begin
            digits_d  = '0;
            valid_d   = '0;
            blank_d   = '0;
            capt_d    = '0;
            idx_d     = '0;
            err_cnt_d = '0;
            update_d  = 1'b0;
            err_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_s_q   <= '0;
            seg_p_q   <= '0;
            an_s_q    <= '0;
            an_p_q    <= '0;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            digits_q  <= '0;
            valid_q   <= '0;
            blank_q   <= '0;
            capt_q    <= '0;
            idx_q     <= '0;
            err_cnt_q <= '0;
            update_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            seg_s_q   <= seg_i;
            an_s_q    <= an_i;
            seg_p_q   <= seg_s_q;
            an_p_q    <= an_s_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            digits_q  <= digits_d;
            valid_q   <= valid_d;
            blank_q   <= blank_d;
            capt_q    <= capt_d;
            idx_q     <= idx_d;
            err_cnt_q <= err_cnt_d;
            update_q  <= update_d;
            err_q     <= err_d;
        end
    end

    assign digits_o       = digits_q;
    assign digit_valid_o  = valid_q;
    assign digit_blank_o  = blank_q;
    assign update_o       = update_q;
    assign digit_idx_o    = idx_q;
    assign err_o          = err_q;
    assign err_count_o    = err_cnt_q;
    assign all_captured_o = &capt_q;

endmodule

// File: tb/tb_seg7_capture_decoder.sv
// Bench for seg7_capture_decoder: predicted commits go into a queue and a monitor pops them
// whenever update_o fires. Build with +define+SEG_HEX_EN to exercise the hex glyphs.
module tb_seg7_capture_decoder;
    localparam int ND = 4;
    localparam int SC = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [6:0]      seg_i;
    logic [ND-1:0]   an_i;
    logic            clear_i;
    logic [4*ND-1:0] digits_o;
    logic [ND-1:0]   digit_valid_o;
    logic [ND-1:0]   digit_blank_o;
    logic            update_o;
    logic [1:0]      digit_idx_o;
    logic            err_o;
    logic [7:0]      err_count_o;
    logic            all_captured_o;

    seg7_capture_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk            (clk),
        .rst            (rst),
        .seg_i          (seg_i),
        .an_i           (an_i),
        .clear_i        (clear_i),
        .digits_o       (digits_o),
        .digit_valid_o  (digit_valid_o),
        .digit_blank_o  (digit_blank_o),
        .update_o       (update_o),
        .digit_idx_o    (digit_idx_o),
        .err_o          (err_o),
        .err_count_o    (err_count_o),
        .all_captured_o (all_captured_o)
    );

    always #5 clk = ~clk;

    int         checks   = 0;
    int         failures = 0;
    bit         mon_en   = 1'b0;
    // Entry: {err, blank, valid, nibble[3:0], idx[1:0]}
    logic [8:0] exp_q[$];
    logic [3:0] m_digits[ND];
    logic [ND-1:0] m_capt;
    int         m_errs;

    // {legal, blank, value}
    function automatic logic [5:0] ref_decode(input logic [6:0] s);
        case (s)
            7'b1111110: return 6'h20;
            7'b0110000: return 6'h21;
            7'b1101101: return 6'h22;
            7'b1111001: return 6'h23;
            7'b0110011: return 6'h24;
            7'b1011011: return 6'h25;
            7'b1011111: return 6'h26;
            7'b1110000: return 6'h27;
            7'b1111111: return 6'h28;
            7'b1111011: return 6'h29;
`ifdef SEG_HEX_EN
            7'b1110111: return 6'h2A;
            7'b0011111: return 6'h2B;
            7'b1001110: return 6'h2C;
            7'b0111101: return 6'h2D;
            7'b1001111: return 6'h2E;
            7'b1000111: return 6'h2F;
`endif
            7'b0000000: return 6'h10;
            default:    return 6'h00;
        endcase
    endfunction

    task automatic model_clear();
        for (int i = 0; i < ND; i++) m_digits[i] = 4'h0;
        m_capt = '0;
        m_errs = 0;
    endtask

    task automatic predict(input int idx, input logic [6:0] s);
        logic [5:0] d;
        logic [3:0] nib;
        logic       err;
        logic [1:0] i2;
        d   = ref_decode(s);
        err = !d[5] && !d[4];
        nib = d[5] ? d[3:0] : (d[4] ? 4'h0 : m_digits[idx]);
        m_digits[idx] = nib;
        m_capt[idx]   = 1'b1;
        if (err) m_errs++;
        i2 = 2'(idx);
        exp_q.push_back({err, d[4], d[5], nib, i2});
    endtask

    // Called at a negedge; holds the pattern for 'hold' rising edges.
    task automatic drive_digit(input int idx, input logic [6:0] s, input int hold);
        an_i  = ND'(1) << idx;
        seg_i = s;
        if (hold >= SC) predict(idx, s);
        repeat (hold) @(negedge clk);
    endtask

    task automatic gap(input int n);
        an_i  = '0;
        seg_i = '0;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        gap(SC + 3);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_update pending=%0d required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    always @(posedge clk) begin : monitor
        logic [8:0] e;
        logic [8:0] obs;
        int         i;
        #1;
        if (mon_en) begin
            if (update_o) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_update idx=%0d err=%0b required=no_update", digit_idx_o, err_o);
                end else begin
                    e   = exp_q.pop_front();
                    i   = int'(e[1:0]);
                    obs = {err_o, digit_blank_o[i], digit_valid_o[i], digits_o[i*4 +: 4], digit_idx_o};
                    if (obs !== e) begin
                        failures++;
                        $display("FAIL commit got={err,blank,valid,nib,idx}=%b required=%b", obs, e);
                    end
                end
            end else if (err_o) begin
                checks++;
                failures++;
                $display("FAIL err_without_update err_o=1 required=0");
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1; clear_i = 1'b0; an_i = '0; seg_i = '0;
        model_clear();
        repeat (3) @(negedge clk);
        checks++;
        if ({digits_o, digit_valid_o, digit_blank_o} !== '0) begin
            failures++;
            $display("FAIL reset_data got=%h required=0", {digits_o, digit_valid_o, digit_blank_o});
        end
        checks++;
        if ({update_o, digit_idx_o, err_o, err_count_o, all_captured_o} !== '0) begin
            failures++;
            $display("FAIL reset_ctrl got=%h required=0", {update_o, digit_idx_o, err_o, err_count_o, all_captured_o});
        end
        rst = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;
    endtask

    task automatic test_latency();
        logic exp_upd;
        an_i  = 4'b0001;
        seg_i = 7'b1111001;
        predict(0, 7'b1111001);
        for (int e = 0; e < 12; e++) begin
            @(posedge clk);
            #1;
            exp_upd = (e == SC);
            checks++;
            if (update_o !== exp_upd) begin
                failures++;
                $display("FAIL latency edge=%0d update_o=%b required=%b", e, update_o, exp_upd);
            end
        end
        @(negedge clk);
        checks++;
        if (digits_o[3:0] !== 4'h3 || digit_valid_o !== 4'b0001 || digit_idx_o !== 2'd0) begin
            failures++;
            $display("FAIL latency_value nib=%h valid=%b idx=%0d required=3 0001 0", digits_o[3:0], digit_valid_o, digit_idx_o);
        end
        drain();
    endtask

    task automatic test_restart();
        drive_digit(2, 7'b0110011, 2);
        drive_digit(2, 7'b1011011, SC + 3);
        drain();
        checks++;
        if (digits_o[11:8] !== 4'h5) begin
            failures++;
            $display("FAIL restart nib2=%h required=5", digits_o[11:8]);
        end
    endtask

    task automatic test_ghost();
        an_i = 4'b0011;
        for (int i = 0; i < 20; i++) begin
            seg_i = 7'($urandom_range(0, 127));
            @(negedge clk);
        end
        drive_digit(3, 7'b0000000, SC + 2);
        drain();
        checks++;
        if (digit_blank_o[3] !== 1'b1 || digit_valid_o[3] !== 1'b0) begin
            failures++;
            $display("FAIL ghost_blank blank3=%b valid3=%b required=1 0", digit_blank_o[3], digit_valid_o[3]);
        end
    endtask

    task automatic test_errors();
        int exp_cnt;
        for (int n = 0; n < 300; n++) begin
            drive_digit(1, 7'b1000000, SC);
            drive_digit(1, 7'b0000000, SC);
        end
        drain();
        exp_cnt = (m_errs > 255) ? 255 : m_errs;
        checks++;
        if (err_count_o !== 8'(exp_cnt)) begin
            failures++;
            $display("FAIL err_saturate got=%0d required=%0d", err_count_o, exp_cnt);
        end
        // Clear lands exactly on the commit edge of a stable digit.
        an_i  = 4'b0001;
        seg_i = 7'b1111011;
        repeat (SC) @(negedge clk);
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        an_i    = '0;
        seg_i   = '0;
        model_clear();
        checks++;
        if ({digits_o, digit_valid_o, digit_blank_o, update_o, digit_idx_o, err_o, err_count_o, all_captured_o} !== '0) begin
            failures++;
            $display("FAIL clear_on_commit got=%h required=0",
                     {digits_o, digit_valid_o, digit_blank_o, update_o, digit_idx_o, err_o, err_count_o, all_captured_o});
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [6:0] pats[4];
        logic       exp_all;
        pats[0] = 7'b1111011;
        pats[1] = 7'b1111111;
        pats[2] = 7'b1110000;
        pats[3] = 7'b1011111;
        for (int i = 0; i < 4; i++) begin
            drive_digit(i, pats[i], SC + 2);
            exp_all = (i == 3);
            checks++;
            if (all_captured_o !== exp_all) begin
                failures++;
                $display("FAIL all_captured step=%0d got=%b required=%b", i, all_captured_o, exp_all);
            end
        end
        drain();
        checks++;
        if (digits_o !== 16'h6789) begin
            failures++;
            $display("FAIL scan_digits got=%h required=6789", digits_o);
        end
    endtask

    task automatic test_hex();
        logic [5:0] d;
        d = ref_decode(7'b1110111);
        drive_digit(0, 7'b1110111, SC + 2);
        drain();
        checks++;
        if (digit_valid_o[0] !== d[5] || digits_o[3:0] !== m_digits[0] || err_count_o !== 8'(m_errs)) begin
            failures++;
            $display("FAIL hex_a valid0=%b nib0=%h errs=%0d required=%b %h %0d",
                     digit_valid_o[0], digits_o[3:0], err_count_o, d[5], m_digits[0], m_errs);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_restart();
        test_ghost();
        test_errors();
        test_back_to_back();
        test_hex();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
